vending_controller_gen: RTL and testbench

Parametrised successor to the two-product, quarter-only vending controller. It accumulates credit from quarter and dollar inputs and serves one of NUM_PRODUCTS products, each with its own price. Change is dispensed one quarter per cycle, and a cancel input refunds all held credit. It sits between the coin/selection front-end and the product and coin-return actuators.

---
 rtl/vending_pkg.sv | 21 ++
 rtl/vending_controller_gen_if.sv | 30 +++
 rtl/vend_select_arbiter.sv | 26 ++
 rtl/vending_controller_gen.sv | 117 +++++++++++
 tb/tb_vending_controller_gen.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/vending_pkg.sv
// Shared types and constants for the parametrised vending controller.
// Includes the state encoding, coin values and a helper that extracts one price from the packed table.
package vending_pkg;

    typedef enum logic [1:0] {IDLE, VEND, CHANGE} vend_state_e;

    localparam int unsigned QUARTER_VAL = 1;
    localparam int unsigned DOLLAR_VAL  = 4;

    // Wide enough for 16 products at up to 16-bit credit.
    localparam int unsigned PRICE_VEC_W = 256;

    function automatic int unsigned price_slice(input logic [PRICE_VEC_W-1:0] prices,
                                                input int unsigned idx,
                                                input int unsigned w);
        logic [PRICE_VEC_W-1:0] mask;
        mask = (PRICE_VEC_W'(1) << w) - PRICE_VEC_W'(1);
        return 32'((prices >> (idx * w)) & mask);
    endfunction

endpackage

// File: rtl/vending_controller_gen_if.sv
// Coin/selection front-end to controller bus.
// The master side drives coins and requests. The slave side returns the vend and change actuator pulses and status.
interface vending_controller_gen_if #(
    parameter int NUM_PRODUCTS = 4,
    parameter int MAX_CREDIT   = 8
);
    localparam int CREDIT_W = $clog2(MAX_CREDIT + 1);

    logic                    quarter_in;
    logic                    dollar_in;
    logic [NUM_PRODUCTS-1:0] select;
    logic                    cancel;
    logic [NUM_PRODUCTS-1:0] product;
    logic                    quarter_out;
    logic                    coin_reject;
    logic                    insufficient;
    logic [CREDIT_W-1:0]     credit;
    logic                    busy;

    modport master (
        output quarter_in, dollar_in, select, cancel,
        input  product, quarter_out, coin_reject, insufficient, credit, busy
    );

    modport slave (
        input  quarter_in, dollar_in, select, cancel,
        output product, quarter_out, coin_reject, insufficient, credit, busy
    );

endinterface

// File: rtl/vend_select_arbiter.sv
// Lowest-index priority encoder for the product request vector.
// Produces a valid flag, the winning index and its one-hot form.
module vend_select_arbiter #(
    parameter  int NUM_PRODUCTS = 4,
    localparam int IDX_W        = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1
) (
    input  logic [NUM_PRODUCTS-1:0] select,
    output logic                    valid,
    output logic [IDX_W-1:0]        index,
    output logic [NUM_PRODUCTS-1:0] onehot
);

    always_comb begin
        valid  = 1'b0;
        index  = '0;
        onehot = '0;
        for (int unsigned i = 0; i < NUM_PRODUCTS; i++) begin
            if (select[i] && !valid) begin
                valid     = 1'b1;
                index     = IDX_W'(i);
                onehot[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vending_controller_gen.sv
// Multi-product vending controller: accumulates quarter/dollar credit, vends one product at a time,
// and returns change or a cancelled credit one quarter per cycle.
module vending_controller_gen
    import vending_pkg::*;
#(
    parameter int NUM_PRODUCTS = 4,
    parameter int MAX_CREDIT   = 8,
    parameter logic [NUM_PRODUCTS*$clog2(MAX_CREDIT+1)-1:0] PRICES = 16'h6432
) (
    input  logic                  clk,
    input  logic                  rnot,
    vending_controller_gen_if.slave bus
);

    localparam int unsigned CREDIT_W = $clog2(MAX_CREDIT + 1);
    localparam int unsigned SUM_W    = CREDIT_W + 3;
    localparam int          IDX_W    = (NUM_PRODUCTS > 1) ? $clog2(NUM_PRODUCTS) : 1;
    localparam logic [PRICE_VEC_W-1:0] PRICES_EXT = PRICE_VEC_W'(PRICES);

    vend_state_e             state;
    logic                    sel_valid;
    logic [IDX_W-1:0]        sel_idx;
    logic [NUM_PRODUCTS-1:0] sel_onehot;
    logic [CREDIT_W-1:0]     price_k;
    logic                    coin_any;
    logic [SUM_W-1:0]        coin_sum;
    logic                    coin_fits;

    vend_select_arbiter #(
        .NUM_PRODUCTS(NUM_PRODUCTS)
    ) u_arbiter (
        .select (bus.select),
        .valid  (sel_valid),
        .index  (sel_idx),
        .onehot (sel_onehot)
    );

    // Coin sum is formed wider than credit so an overflowing coin is detected, not wrapped.
    always_comb begin
        price_k   = CREDIT_W'(price_slice(PRICES_EXT, 32'(sel_idx), CREDIT_W));
        coin_any  = bus.quarter_in | bus.dollar_in;
        coin_sum  = SUM_W'(bus.credit)
                  + (bus.quarter_in ? SUM_W'(QUARTER_VAL) : '0)
                  + (bus.dollar_in  ? SUM_W'(DOLLAR_VAL)  : '0);
        coin_fits = (coin_sum <= SUM_W'(MAX_CREDIT));
    end

    always_ff @(posedge clk or negedge rnot) begin
        if (!rnot) begin
            state            <= IDLE;
            bus.credit       <= '0;
            bus.product      <= '0;
            bus.quarter_out  <= 1'b0;
            bus.coin_reject  <= 1'b0;
            bus.insufficient <= 1'b0;
            bus.busy         <= 1'b0;
        end else begin
            bus.product      <= '0;
            bus.quarter_out  <= 1'b0;
            bus.coin_reject  <= 1'b0;
            bus.insufficient <= 1'b0;
            case (state)
                IDLE: begin
                    if (sel_valid) begin
                        bus.coin_reject <= coin_any;
                        if (bus.credit >= price_k) begin
                            state       <= VEND;
                            bus.credit  <= bus.credit - price_k;
                            bus.product <= sel_onehot;
                            bus.busy    <= 1'b1;
                        end else begin
                            bus.insufficient <= 1'b1;
                        end
                    end else if (bus.cancel && (bus.credit != '0)) begin
                        state           <= CHANGE;
                        bus.quarter_out <= 1'b1;
                        bus.coin_reject <= coin_any;
                        bus.busy        <= 1'b1;
                    end else if (coin_any) begin
                        if (coin_fits) begin
                            bus.credit <= coin_sum[CREDIT_W-1:0];
                        end else begin
                            bus.coin_reject <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    bus.coin_reject <= coin_any;
                    if (bus.credit != '0) begin
                        state           <= CHANGE;
                        bus.quarter_out <= 1'b1;
                    end else begin
                        state    <= IDLE;
                        bus.busy <= 1'b0;
                    end
                end
                CHANGE: begin
                    // quarter_out is already high for this cycle; the edge retires that quarter.
                    bus.coin_reject <= coin_any;
                    if (bus.credit > CREDIT_W'(1)) begin
                        bus.credit      <= bus.credit - CREDIT_W'(1);
                        bus.quarter_out <= 1'b1;
                    end else begin
                        bus.credit <= '0;
                        state      <= IDLE;
                        bus.busy   <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vending_controller_gen.sv
// Directed bench for vending_controller_gen with hand-computed expectations.
// Default prices are p0=2, p1=3, p2=4, p3=6, and MAX_CREDIT is 8.
module tb_vending_controller_gen;

    logic clk;
    logic rnot;
    int   checks;
    int   failures;
    int   qcount;

    vending_controller_gen_if #(.NUM_PRODUCTS(4), .MAX_CREDIT(8)) bus ();

    vending_controller_gen #(
        .NUM_PRODUCTS(4),
        .MAX_CREDIT(8),
        .PRICES(16'h6432)
    ) u_dut (
        .clk  (clk),
        .rnot (rnot),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Apply inputs for one edge, then clear them; outputs are observed 1 time unit after that edge.
    task automatic step(input logic q, input logic d, input logic [3:0] sel, input logic c);
        bus.quarter_in = q;
        bus.dollar_in  = d;
        bus.select     = sel;
        bus.cancel     = c;
        @(posedge clk);
        #1;
        bus.quarter_in = 1'b0;
        bus.dollar_in  = 1'b0;
        bus.select     = 4'b0000;
        bus.cancel     = 1'b0;
        if (bus.quarter_out === 1'b1) qcount++;
    endtask

    task automatic idle_step();
        step(1'b0, 1'b0, 4'b0000, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        qcount   = 0;
        bus.quarter_in = 1'b0;
        bus.dollar_in  = 1'b0;
        bus.select     = 4'b0000;
        bus.cancel     = 1'b0;
        rnot = 1'b0;
        #12;
        check("rst_credit",  32'(bus.credit), 0);
        check("rst_product", 32'(bus.product), 0);
        check("rst_qout",    32'(bus.quarter_out), 0);
        check("rst_busy",    32'(bus.busy), 0);
        @(posedge clk);
        #1;
        rnot = 1'b1;

        // 1: three quarters, buy p1 (price 3)
        repeat (3) step(1'b1, 1'b0, 4'b0000, 1'b0);
        check("t1_credit3", 32'(bus.credit), 3);
        step(1'b0, 1'b0, 4'b0010, 1'b0);
        check("t1_product", 32'(bus.product), 32'h2);
        check("t1_credit0", 32'(bus.credit), 0);
        check("t1_busy",    32'(bus.busy), 1);
        check("t1_qout",    32'(bus.quarter_out), 0);
        idle_step();
        check("t1_prod_off", 32'(bus.product), 0);
        check("t1_busy_off", 32'(bus.busy), 0);
        check("t1_qout_off", 32'(bus.quarter_out), 0);

        // cancel with zero credit is ignored
        step(1'b0, 1'b0, 4'b0000, 1'b1);
        check("c0_busy", 32'(bus.busy), 0);
        check("c0_qout", 32'(bus.quarter_out), 0);

        // 2: dollar+quarter together = 5, buy p0 (price 2), three quarters change
        step(1'b1, 1'b1, 4'b0000, 1'b0);
        check("t2_credit5", 32'(bus.credit), 5);
        step(1'b0, 1'b0, 4'b0001, 1'b0);
        check("t2_product", 32'(bus.product), 32'h1);
        check("t2_credit3", 32'(bus.credit), 3);
        qcount = 0;
        idle_step();
        check("t2_q1", 32'(bus.quarter_out), 1);
        check("t2_c3", 32'(bus.credit), 3);
        idle_step();
        check("t2_q2", 32'(bus.quarter_out), 1);
        check("t2_c2", 32'(bus.credit), 2);
        idle_step();
        check("t2_q3", 32'(bus.quarter_out), 1);
        check("t2_c1", 32'(bus.credit), 1);
        idle_step();
        check("t2_qend", 32'(bus.quarter_out), 0);
        check("t2_c0",   32'(bus.credit), 0);
        check("t2_busy", 32'(bus.busy), 0);
        check("t2_qcount", 32'(qcount), 3);

        // 3: one quarter, p2 (price 4) refused, then cancel
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        step(1'b0, 1'b0, 4'b0100, 1'b0);
        check("t3_insuff",  32'(bus.insufficient), 1);
        check("t3_credit1", 32'(bus.credit), 1);
        check("t3_busy",    32'(bus.busy), 0);
        idle_step();
        check("t3_insuff_off", 32'(bus.insufficient), 0);
        qcount = 0;
        step(1'b0, 1'b0, 4'b0000, 1'b1);
        check("t3_qout", 32'(bus.quarter_out), 1);
        idle_step();
        idle_step();
        check("t3_qcount", 32'(qcount), 1);
        check("t3_credit0", 32'(bus.credit), 0);

        // 4: overflow reject, fill to exactly MAX, refund with a coin during change
        step(1'b0, 1'b1, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        check("t4_credit6", 32'(bus.credit), 6);
        step(1'b0, 1'b1, 4'b0000, 1'b0);
        check("t4_reject", 32'(bus.coin_reject), 1);
        check("t4_keep6",  32'(bus.credit), 6);
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        check("t4_credit7", 32'(bus.credit), 7);
        check("t4_rej_off", 32'(bus.coin_reject), 0);
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        check("t4_credit8", 32'(bus.credit), 8);
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        check("t4_rej_full", 32'(bus.coin_reject), 1);
        check("t4_keep8",    32'(bus.credit), 8);
        qcount = 0;
        step(1'b0, 1'b0, 4'b0000, 1'b1);
        check("t4_chg_c8", 32'(bus.credit), 8);
        step(1'b0, 1'b1, 4'b0000, 1'b0);
        check("t4_rej_chg", 32'(bus.coin_reject), 1);
        check("t4_chg_c7",  32'(bus.credit), 7);
        repeat (7) idle_step();
        check("t4_qcount", 32'(qcount), 8);
        check("t4_c0",     32'(bus.credit), 0);
        check("t4_busy",   32'(bus.busy), 0);

        // 5: select two products with a coin in the same cycle
        step(1'b0, 1'b1, 4'b0000, 1'b0);
        qcount = 0;
        step(1'b1, 1'b0, 4'b0110, 1'b0);
        check("t5_product", 32'(bus.product), 32'h2);
        check("t5_reject",  32'(bus.coin_reject), 1);
        check("t5_credit1", 32'(bus.credit), 1);
        idle_step();
        check("t5_qout", 32'(bus.quarter_out), 1);
        idle_step();
        idle_step();
        check("t5_qcount", 32'(qcount), 1);
        check("t5_c0",     32'(bus.credit), 0);

        // 6: reset asserted during change
        step(1'b1, 1'b1, 4'b0000, 1'b0);
        step(1'b0, 1'b0, 4'b0001, 1'b0);
        idle_step();
        check("t6_qout_pre", 32'(bus.quarter_out), 1);
        rnot = 1'b0;
        #1;
        check("t6_rst_qout",   32'(bus.quarter_out), 0);
        check("t6_rst_credit", 32'(bus.credit), 0);
        check("t6_rst_busy",   32'(bus.busy), 0);
        check("t6_rst_prod",   32'(bus.product), 0);
        @(posedge clk);
        #1;
        rnot = 1'b1;
        qcount = 0;
        repeat (5) idle_step();
        check("t6_no_qout", 32'(qcount), 0);
        check("t6_busy",    32'(bus.busy), 0);
        check("t6_credit",  32'(bus.credit), 0);
        // back in IDLE: a quarter is accepted
        step(1'b1, 1'b0, 4'b0000, 1'b0);
        check("t6_idle_coin", 32'(bus.credit), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
